sag_perm_seq: RTL and testbench
===============================

// Module: sag_perm_seq
// PURPOSE
//  Sequential 8-bit bit-permutation engine built on the 8-bit Sheep-And-Goats (SAG) op.
//  Each accepted byte goes through NSTAGES back-to-back SAG passes, one per cycle.
//  Each pass uses its own programmable control word.
//  Sits downstream of a byte producer (valid/ready) and upstream of a byte consumer.
//  Realises arbitrary 8-bit permutations (3 passes suffice) without a full crossbar.
// PARAMETERS
//  NSTAGES  3  number of SAG passes per byte; legal 1..4
// PORTS
//  clk       in   1  single clock; all state updates on rising edge
//  resetn    in   1  synchronous reset, active-low
//  cfg_we    in   1  control-word write strobe
//  cfg_idx   in   2  control-word index; writes with cfg_idx >= NSTAGES are ignored
//  cfg_data  in   8  control word to write
//  cfg_err   out  1  1-cycle pulse: write dropped because engine not IDLE
//  in_valid  in   1  input byte valid
//  in_ready  out  1  engine can accept a byte
//  in_data   in   8  input byte
//  out_valid out  1  result byte valid
//  out_ready in   1  consumer accepts result
//  out_data  out  8  result byte
//  busy      out  1  state != IDLE
// BEHAVIOUR
//  SAG(d,c): scan i=0..7; if c[i], r[j++]=d[i] (j from 0); else r[k--]=d[i] (k from 7).
//   - Sheep are packed at the LSBs in order; goats are packed at the MSBs in reversed order.
//  Reset (resetn=0 at edge): state=IDLE, ctrl[0..NSTAGES-1]=8'hFF (identity), data=0, cnt=0.
//   - Output values during reset: out_valid=0, out_data=0, in_ready=0, cfg_err=0, busy=0.
//   - in_ready rises the cycle after reset is released.
//  FSM states: IDLE, RUN, DONE.
//   - IDLE: in_ready=1. On in_valid&&in_ready, latch data=in_data, cnt=0, go to RUN.
//   - RUN: each cycle data<=SAG(data,ctrl[cnt]) and cnt<=cnt+1.
//     When cnt==NSTAGES-1, apply the final pass and go to DONE.
//   - DONE: out_valid=1 and out_data=data, both held stable until out_ready.
//     On out_valid&&out_ready, go to IDLE.
//  Latency: input accepted at edge T; out_valid first visible after edge T+NSTAGES.
//   - Throughput: one byte per NSTAGES+2 cycles. IDLE is never skipped.
//   - in_ready=0 in RUN and DONE, so no overlap between bytes.
//  Config writes:
//   - Applied only in IDLE; they take effect for the next accepted byte.
//   - A write in RUN or DONE is dropped, ctrl is unchanged, and cfg_err pulses for 1 cycle.
//   - cfg_we in the same IDLE cycle as an input accept: the write lands, but the accepted byte
//     uses the new value only if the stage reads it later (all stages read at RUN time).
//  Arithmetic: cnt is 2 bits; no wrap is reachable for NSTAGES<=4.
//   - Out-of-range cfg_idx: silent ignore, no cfg_err.
//  Reset mid-operation: the in-flight byte is discarded and all state returns to reset values.
//  out_ready while not in DONE: ignored.
// CONFIGURATION
//  SAG_PERM_PEXT_EN defined:
//   - Adds input port in_pext (1 bit), sampled together with in_data on accept.
//   - If in_pext is set, every pass computes SAG(data & ctrl, ctrl), i.e. parallel-extract:
//     goat bits are zeroed.
//  SAG_PERM_PEXT_EN undefined: port absent; passes are always plain SAG.
// TESTING
//  1 Reset, no cfg. Input 8'hA5 accepted at T: out_data=8'hA5, out_valid rises after edge T+3.
//  2 Write ctrl0=8'h0F, ctrl1=ctrl2=FF. Input 8'h35: out_data=8'hC5.
//  3 Write ctrl0=8'h00 (bit reverse), others FF.
//    Input 8'h2C gives 8'h34; input 8'h01 gives 8'h80.
//  4 out_ready=0 for 5 cycles in DONE:
//    out_valid and out_data held, in_ready=0, a concurrent in_valid byte is not accepted.
//  5 cfg_we (idx 0, 8'h00) during RUN: cfg_err=1 for exactly 1 cycle.
//    The result equals the identity path; ctrl0 is still 8'hFF afterwards.
//  6 resetn=0 for 1 cycle mid-RUN:
//    Next cycle out_valid=0, busy=0, ctrl reset to FF; the next byte passes unchanged.
//  7 (PEXT_EN) ctrl0=8'h0F, others FF, in_pext=1, input 8'hFF: out_data=8'h0F.

Source files
------------

// File: rtl/sag_perm_seq.sv
// sag_perm_seq: 8-bit Sheep-And-Goats permutation engine, NSTAGES passes per byte (optional SAG_PERM_PEXT_EN adds in_pext parallel-extract mode).
// Latency: byte accepted at edge T, out_valid after edge T+NSTAGES; one byte per NSTAGES+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; config writes outside IDLE are dropped with a cfg_err pulse.
module sag_perm_seq #(
    parameter int NSTAGES = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       cfg_we,
    input  logic [1:0] cfg_idx,
    input  logic [7:0] cfg_data,
    output logic       cfg_err,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
`ifdef SAG_PERM_PEXT_EN
    input  logic       in_pext,
`endif
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] LAST_CNT = 2'(NSTAGES - 1);

    state_t     state_q, state_d;
    logic [7:0] ctrl_q [NSTAGES];
    logic [7:0] ctrl_d [NSTAGES];
    logic [7:0] data_q, data_d;
    logic [1:0] cnt_q, cnt_d;
    logic       rdy_en_q;
    logic       cfg_err_q, cfg_err_d;
    logic       pext_q, pext_d;

    logic       accept;
    logic       idx_ok;
    logic [7:0] ctrl_sel;
    logic [7:0] pass_in;

    // Sheep (ctrl=1) pack upward from bit 0; goats pack downward from bit 7.
    function automatic logic [7:0] sag8(input logic [7:0] d, input logic [7:0] c);
        logic [7:0] r;
        logic [2:0] j;
        logic [2:0] k;
        r = '0;
        j = 3'd0;
        k = 3'd7;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) begin
                r[j] = d[i];
                j    = j + 3'd1;
            end else begin
                r[k] = d[i];
                k    = k - 3'd1;
            end
        end
        return r;
    endfunction

    assign accept = in_valid && in_ready;
    assign idx_ok = (int'(cfg_idx) < NSTAGES);

    always_comb begin
        ctrl_sel = 8'hFF;
        for (int s = 0; s < NSTAGES; s++) begin
            if (cnt_q == 2'(s)) begin
                ctrl_sel = ctrl_q[s];
            end
        end
    end

    always_comb begin
        pass_in = data_q;
        if (pext_q) begin
            pass_in = data_q & ctrl_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            data_q    <= 8'h00;
            cnt_q     <= 2'd0;
            rdy_en_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            pext_q    <= 1'b0;
            for (int s = 0; s < NSTAGES; s++) begin
                ctrl_q[s] <= 8'hFF;
            end
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            rdy_en_q  <= 1'b1;
            cfg_err_q <= cfg_err_d;
            pext_q    <= pext_d;
            for (int s = 0; s < NSTAGES; s++) begin
                ctrl_q[s] <= ctrl_d[s];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST_CNT) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        pext_d = pext_q;
        if (state_q == S_IDLE && accept) begin
            data_d = in_data;
            cnt_d  = 2'd0;
`ifdef SAG_PERM_PEXT_EN
            pext_d = in_pext;
`else
            pext_d = 1'b0;
`endif
        end else if (state_q == S_RUN) begin
            data_d = sag8(pass_in, ctrl_sel);
            cnt_d  = (cnt_q == LAST_CNT) ? 2'd0 : cnt_q + 2'd1;
        end
    end

    // Control words only change between bytes, so a pass never sees a half-updated set.
    always_comb begin
        ctrl_d    = ctrl_q;
        cfg_err_d = 1'b0;
        if (cfg_we && idx_ok) begin
            if (state_q == S_IDLE) begin
                for (int s = 0; s < NSTAGES; s++) begin
                    if (cfg_idx == 2'(s)) begin
                        ctrl_d[s] = cfg_data;
                    end
                end
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready  = resetn && rdy_en_q && (state_q == S_IDLE);
        out_valid = resetn && (state_q == S_DONE);
        out_data  = out_valid ? data_q : 8'h00;
        busy      = resetn && (state_q != S_IDLE);
        cfg_err   = resetn && cfg_err_q;
    end

endmodule

// File: tb/tb_sag_perm_seq.sv
// Bench for sag_perm_seq: directed cases followed by random bytes/configs against a queue-based SAG reference.
module tb_sag_perm_seq;

    localparam int NST = 3;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [7:0] cfg_data;
    logic       cfg_err;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
`ifdef SAG_PERM_PEXT_EN
    logic       in_pext;
`endif
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] ctrl_m [NST];

    sag_perm_seq #(.NSTAGES(NST)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
`ifdef SAG_PERM_PEXT_EN
        .in_pext   (in_pext),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference SAG: sheep in scan order, then goats in reverse scan order, filled from bit 0 upward.
    function automatic logic [7:0] sag_ref(input logic [7:0] d, input logic [7:0] c);
        logic       sheep [$];
        logic       goats [$];
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) sheep.push_back(d[i]);
            else      goats.push_front(d[i]);
        end
        foreach (goats[i]) sheep.push_back(goats[i]);
        for (int i = 0; i < 8; i++) r[i] = sheep[i];
        return r;
    endfunction

    function automatic logic [7:0] expect_byte(input logic [7:0] d, input bit px);
        logic [7:0] v;
        v = d;
        for (int s = 0; s < NST; s++) begin
            if (px) v = v & ctrl_m[s];
            v = sag_ref(v, ctrl_m[s]);
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NST; s++) ctrl_m[s] = 8'hFF;
    endtask

    task automatic model_write(input logic [1:0] idx, input logic [7:0] dat);
        if (int'(idx) < NST) ctrl_m[idx] = dat;
    endtask

    task automatic cfg_idle(input logic [1:0] idx, input logic [7:0] dat);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_data = dat;
        model_write(idx, dat);
        @(negedge clk);
        cfg_we = 1'b0;
        chk("cfg_err_idle", 32'(cfg_err), 0);
    endtask

    task automatic send(input logic [7:0] d, input bit px, input int stall,
                        input bit wr, input logic [1:0] widx, input logic [7:0] wdat,
                        input bit run_wr, output logic [7:0] got);
        logic [7:0] exp;
        int n;
        int errs;
        @(negedge clk);
        chk("in_ready_idle", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = d;
`ifdef SAG_PERM_PEXT_EN
        in_pext  = px;
`endif
        if (wr) begin
            cfg_we   = 1'b1;
            cfg_idx  = widx;
            cfg_data = wdat;
            model_write(widx, wdat);
        end
        exp = expect_byte(d, px);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        in_data  = 8'($urandom);
        chk("in_ready_run", 32'(in_ready), 0);
        errs = 0;
        if (run_wr) begin
            cfg_we   = 1'b1;
            cfg_idx  = 2'd0;
            cfg_data = 8'h00;
        end
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            cfg_we = 1'b0;
            n++;
            if (cfg_err) errs++;
            out_ready = out_valid ? 1'b0 : 1'($urandom);
        end
        chk("latency", n, NST);
        chk("out_data", 32'(out_data), 32'(exp));
        got = out_data;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
            if (cfg_err) errs++;
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_data", 32'(out_data), 32'(exp));
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (cfg_err) errs++;
        chk("handoff_valid", 32'(out_valid), 0);
        chk("handoff_busy", 32'(busy), 0);
        chk("cfg_err_pulses", errs, run_wr ? 1 : 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        logic [7:0] d;
        bit         px;
        resetn    = 1'b0;
        cfg_we    = 1'b0;
        cfg_idx   = 2'd0;
        cfg_data  = 8'h00;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
`ifdef SAG_PERM_PEXT_EN
        in_pext   = 1'b0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        resetn = 1'b1;
        chk("rel_in_ready_low", 32'(in_ready), 0);
        @(negedge clk);
        chk("rel_in_ready_high", 32'(in_ready), 1);

        send(8'hA5, 1'b0, 0, 1'b0, 2'd0, 8'h00, 1'b0, got);
        chk("t1_identity", 32'(got), 32'h0A5);

        cfg_idle(2'd0, 8'h0F);
        send(8'h35, 1'b0, 0, 1'b0, 2'd0, 8'h00, 1'b0, got);
        chk("t2_c0f", 32'(got), 32'h0C5);

        cfg_idle(2'd0, 8'h00);
        send(8'h2C, 1'b0, 0, 1'b0, 2'd0, 8'h00, 1'b0, got);
        chk("t3_rev_2c", 32'(got), 32'h034);
        send(8'h01, 1'b0, 0, 1'b0, 2'd0, 8'h00, 1'b0, got);
        chk("t3_rev_01", 32'(got), 32'h080);

        send(8'h96, 1'b0, 5, 1'b0, 2'd0, 8'h00, 1'b0, got);

        cfg_idle(2'd0, 8'hFF);
        send(8'h6B, 1'b0, 0, 1'b0, 2'd0, 8'h00, 1'b1, got);
        chk("t5_dropped_write", 32'(got), 32'h06B);
        send(8'hD2, 1'b0, 0, 1'b0, 2'd0, 8'h00, 1'b0, got);
        chk("t5_ctrl_kept", 32'(got), 32'h0D2);

        // Reset in the middle of a byte with a non-identity config loaded.
        cfg_idle(2'd1, 8'h00);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        resetn   = 1'b0;
        @(negedge clk);
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_in_ready", 32'(in_ready), 0);
        resetn = 1'b1;
        model_reset();
        @(negedge clk);
        chk("t6_in_ready_back", 32'(in_ready), 1);
        send(8'h3C, 1'b0, 0, 1'b0, 2'd0, 8'h00, 1'b0, got);
        chk("t6_identity", 32'(got), 32'h03C);

`ifdef SAG_PERM_PEXT_EN
        cfg_idle(2'd0, 8'h0F);
        send(8'hFF, 1'b1, 0, 1'b0, 2'd0, 8'h00, 1'b0, got);
        chk("t7_pext", 32'(got), 32'h00F);
`endif

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(2) == 0) cfg_idle(2'($urandom), 8'($urandom));
            d  = 8'($urandom);
            px = 1'b0;
`ifdef SAG_PERM_PEXT_EN
            px = 1'($urandom);
`endif
            send(d, px, int'($urandom_range(3)), ($urandom_range(3) == 0),
                 2'($urandom), 8'($urandom), ($urandom_range(3) == 0), got);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
